debounce_edge: RTL and testbench
================================

Name: debounce_edge

Overview:
- Conditioning stage directly downstream of the single-bit dff.
- Takes the dff's q as its raw input `d` and re-synchronises it with a second flop stage.
- Filters the signal and produces a debounced level plus one-cycle rise/fall strobes.
- Consumers use it for push-button or asynchronous control inputs that must be glitch-free before they reach counters or FSMs.

Parameters:
- STABLE_CYCLES, 8: number of consecutive synchronised samples at a new level required before the output changes. Legal range is 2 to 2^CNT_W.
- CNT_W, 4: width of the internal stability counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
- d  input  1  raw level, normally the q output of the upstream dff.
- q  output  1  debounced level.
- rise  output  1  one-cycle pulse when q goes 0->1.
- fall  output  1  one-cycle pulse when q goes 1->0.
- busy  output  1  high while a candidate transition is being qualified.

Behaviour:
- Reset (rst=1 at a rising edge): s1, s2, cnt, q, rise, fall and busy all clear to 0; state becomes IDLE_LO. Reset overrides all other activity, including mid-qualification; the partial count is discarded.
- Synchroniser: on every edge, s1<=d and s2<=s1. Only s2 feeds the FSM.
- FSM states: IDLE_LO, WAIT_HI, IDLE_HI, WAIT_LO.
- Unused state encodings recover to IDLE_LO on the next edge.
- IDLE_LO:
  - s2=1 -> WAIT_HI, cnt<=1.
  - Otherwise stay, cnt<=0.
- WAIT_HI:
  - s2=0 -> IDLE_LO, cnt<=0; glitch rejected, no pulse.
  - s2=1 and cnt==STABLE_CYCLES-1 -> IDLE_HI, q<=1, rise<=1, cnt<=0.
  - Otherwise cnt<=cnt+1.
- IDLE_HI and WAIT_LO mirror the above with polarity inverted. Qualification ends with q<=0 and fall<=1.
- rise and fall are registered and high for exactly one cycle. They are never high together and never high while rst is asserted.
- busy = 1 exactly when the state is WAIT_HI or WAIT_LO (registered with the state).
- Latency: if d is 1 before edge 1 and stays 1, q=1 and rise=1 become visible after edge STABLE_CYCLES+2 (edge 10 at defaults). Falling latency is the same.
- Rejection rule: a pulse on s2 lasting at most STABLE_CYCLES-1 cycles produces no change on q, rise or fall. Default: 7 or fewer cycles is rejected; 8 cycles is accepted.
- Counter width: cnt never exceeds STABLE_CYCLES-1, so no wrap-around is possible. Elaboration fails (via $error in an initial check) if STABLE_CYCLES<2 or STABLE_CYCLES>2^CNT_W.
- A bounce during WAIT restarts from the IDLE state for the current level. The next opposite sample re-enters WAIT with cnt=1; the count does not resume.
- An X on d propagates into s1/s2 only. The FSM treats any non-1 value of s2 as 0.

Test Plan:
1. Bench clock has a period of 2000 time units. Hold rst=1 and d=0 for 5 cycles, then release -> q=0, rise=0, fall=0, busy=0, and they stay 0 for 20 cycles.
2. Drive d=1 from just before edge 1 and hold it (defaults) -> busy=1 after edge 3. q=1 and rise=1 after edge 10. rise=0 and busy=0 after edge 11. q stays 1.
3. From settled q=1, drive d=0 for 7 cycles and then back to 1 -> fall never asserts and q stays 1. busy is high during the glitch and returns to 0 two cycles after d returns to 1.
4. From settled q=1, drive d=0 for exactly 8 cycles and then back to 1 -> fall pulses once for 1 cycle and q=0. It then re-qualifies: rise pulses and q=1 ten edges after d returns to 1.
5. Drive d=1 and assert rst=1 while busy=1 with cnt=5 -> after that edge, q=0, busy=0 and cnt=0. After rst is released with d still 1, rise arrives 8 edges after s2 is sampled, not earlier.
6. Drive d with 1-0-1-0 alternating every cycle for 40 cycles -> q=0 throughout and rise/fall never assert. Check rise&fall==0 on every cycle of all tests.

Source files
------------

// File: rtl/debounce_edge.sv
// Two-flop resynchroniser followed by a four-state debounce FSM.
// Emits a clean level plus one-cycle rise/fall strobes.
module debounce_edge #(
  parameter int STABLE_CYCLES = 8,
  parameter int CNT_W         = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall,
  output logic busy
);

  if (STABLE_CYCLES < 2 ||
      STABLE_CYCLES > (1 << CNT_W)) begin : g_bad_cfg
    $error("debounce_edge: STABLE_CYCLES out of range");
  end

  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE_LO = 2'd0,
    WAIT_HI = 2'd1,
    IDLE_HI = 2'd2,
    WAIT_LO = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             s1;
  logic             s2;
  logic             hi;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             q_nxt;
  logic             rise_nxt;
  logic             fall_nxt;
  logic             busy_nxt;

  // Two-stage resynchroniser on the raw input
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= d;
      s2 <= s1;
    end
  end

  // Clean 0/1 view of s2: anything but a definite 1 is low
  always_comb begin
    hi = 1'b0;
    if (s2) hi = 1'b1;
  end

  // State, counter and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE_LO;
      cnt   <= '0;
      q     <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      q     <= q_nxt;
      rise  <= rise_nxt;
      fall  <= fall_nxt;
      busy  <= busy_nxt;
    end
  end

  // Next state: qualify a new level, restart on any bounce
  always_comb begin
    state_nxt = state;
    cnt_nxt   = '0;
    case (state)
      IDLE_LO: begin
        if (hi) begin
          state_nxt = WAIT_HI;
          cnt_nxt   = ONE;
        end
      end
      WAIT_HI: begin
        if (!hi) begin
          state_nxt = IDLE_LO;
        end else if (cnt == LAST) begin
          state_nxt = IDLE_HI;
        end else begin
          cnt_nxt = cnt + ONE;
        end
      end
      IDLE_HI: begin
        if (!hi) begin
          state_nxt = WAIT_LO;
          cnt_nxt   = ONE;
        end
      end
      WAIT_LO: begin
        if (hi) begin
          state_nxt = IDLE_HI;
        end else if (cnt == LAST) begin
          state_nxt = IDLE_LO;
        end else begin
          cnt_nxt = cnt + ONE;
        end
      end
      default: begin
        state_nxt = IDLE_LO;
      end
    endcase
  end

  // Outputs derived from the transition being taken
  always_comb begin
    q_nxt    = (state_nxt == IDLE_HI) ||
               (state_nxt == WAIT_LO);
    rise_nxt = (state == WAIT_HI) &&
               (state_nxt == IDLE_HI);
    fall_nxt = (state == WAIT_LO) &&
               (state_nxt == IDLE_LO);
    busy_nxt = (state_nxt == WAIT_HI) ||
               (state_nxt == WAIT_LO);
  end

endmodule

// File: tb/tb_debounce_edge.sv
// Bench for debounce_edge: directed sequences plus random bounce,
// scoreboarded against a run-length model of the debounce rule.
module tb_debounce_edge;

  localparam int S = 8;

  logic clk;
  logic rst;
  logic d;
  logic q;
  logic rise;
  logic fall;
  logic busy;

  int n_chk;
  int n_fail;

  typedef struct packed {
    logic q;
    logic rise;
    logic fall;
    logic busy;
  } exp_t;

  exp_t sbq[$];

  // model: s2 is d delayed two edges; q flips after S
  // consecutive delayed samples that disagree with it
  logic m_p1;
  logic m_p2;
  logic m_q;
  int   m_run;
  logic m_rise;
  logic m_fall;

  debounce_edge #(.STABLE_CYCLES(S), .CNT_W(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .d    (d),
    .q    (q),
    .rise (rise),
    .fall (fall),
    .busy (busy)
  );

  initial clk = 1'b0;
  always #1000 clk = ~clk;

  task automatic chk(input string nm,
                     input logic got,
                     input logic want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s at %0t: got %b want %b",
               nm, $time, got, want);
    end
  endtask

  task automatic model(input logic rv, input logic dv);
    logic s;
    if (rv) begin
      m_p1 = 0; m_p2 = 0; m_q = 0; m_run = 0;
      m_rise = 0; m_fall = 0;
    end else begin
      s    = m_p2;
      m_p2 = m_p1;
      m_p1 = dv;
      m_rise = 0;
      m_fall = 0;
      if (s != m_q) m_run++;
      else m_run = 0;
      if (m_run == S) begin
        m_q    = s;
        m_rise = s;
        m_fall = !s;
        m_run  = 0;
      end
    end
  endtask

  task automatic step(input logic dv, input logic rv);
    exp_t e;
    d   = dv;
    rst = rv;
    @(posedge clk);
    model(rv, dv);
    e.q    = m_q;
    e.rise = m_rise;
    e.fall = m_fall;
    e.busy = (m_run != 0);
    sbq.push_back(e);
    @(negedge clk);
  endtask

  // Monitor: one output set per cycle, compared away from the edge
  always @(negedge clk) begin
    exp_t e;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk("q", q, e.q);
      chk("rise", rise, e.rise);
      chk("fall", fall, e.fall);
      chk("busy", busy, e.busy);
      chk("rise_and_fall", rise & fall, 1'b0);
    end
  end

  initial begin
    int len;
    logic v;
    n_chk  = 0;
    n_fail = 0;
    d   = 1'b0;
    rst = 1'b1;
    @(negedge clk);

    // reset, then idle low
    repeat (5) step(1'b0, 1'b1);
    repeat (20) step(1'b0, 1'b0);

    // clean rise
    repeat (15) step(1'b1, 1'b0);

    // 7-cycle low glitch is rejected
    repeat (7) step(1'b0, 1'b0);
    repeat (10) step(1'b1, 1'b0);

    // 8-cycle low is accepted, then re-qualify high
    repeat (8) step(1'b0, 1'b0);
    repeat (15) step(1'b1, 1'b0);

    // settle low, then reset mid-qualification
    repeat (12) step(1'b0, 1'b0);
    repeat (7) step(1'b1, 1'b0);
    chk("cnt_before_rst", dut.cnt == 4'd5, 1'b1);
    step(1'b1, 1'b1);
    chk("cnt_after_rst", dut.cnt == 4'd0, 1'b1);
    repeat (14) step(1'b1, 1'b0);

    // settle low, then alternate every cycle
    repeat (12) step(1'b0, 1'b0);
    for (int i = 0; i < 40; i++)
      step(i[0] ? 1'b0 : 1'b1, 1'b0);

    // random bounce with occasional reset
    repeat (40) begin
      v   = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 12);
      repeat (len)
        step(v, $urandom_range(0, 99) == 0);
    end
    repeat (12) step(1'b0, 1'b0);

    for (int i = 0; i < 4 && sbq.size() > 0; i++)
      @(negedge clk);
    if (sbq.size() > 0) begin
      n_fail++;
      $display("FAIL drain: %0d left want 0", sbq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
